cic3_row_readout_serializer: RTL and testbench
==============================================

// Module: cic3_row_readout_serializer
// PURPOSE
//  Downstream consumer of the 1x12 CIC3 filter row. On each decimated-sample strobe it
//  snapshots all 12 x 25-bit filter outputs into shadow registers, then streams them out
//  one channel per transfer over a valid/ready interface, tagged with channel ID and
//  start/end-of-frame flags. Strobes arriving while a frame is still draining are dropped
//  and counted; overrun is flagged.
// PARAMETERS
//  NUM_CH      12  filters per row (channels per frame)
//  DATA_W      25  filter output width
//  CH_W        4   channel-ID width; must satisfy 2**CH_W >= NUM_CH
//  DROP_W      8   width of dropped-frame counter
// PORTS
//  clk         in   1               common filter clock; all logic on rising edge
//  reset       in   1               synchronous, active-high reset
//  in_data     in   NUM_CH*DATA_W   flattened filter outputs; ch j at [j*DATA_W +: DATA_W]
//  in_strobe   in   1               1-cycle pulse: in_data holds a new decimated sample set
//  clr_ovr     in   1               1-cycle pulse: clear overrun flag and drop counter
//  out_data    out  DATA_W          current channel sample
//  out_ch      out  CH_W            channel index of out_data (0..NUM_CH-1)
//  out_sof     out  1               high with out_valid when out_ch==0
//  out_eof     out  1               high with out_valid when out_ch==NUM_CH-1
//  out_valid   out  1               out_data/out_ch/out_sof/out_eof valid
//  out_ready   in   1               consumer accepts current word
//  busy        out  1               high while in DRAIN
//  overrun     out  1               sticky: a strobe was dropped
//  drop_cnt    out  DROP_W          saturating count of dropped strobes
// BEHAVIOUR
//  - Reset (sync, any state, including mid-frame): state=IDLE, out_valid=0, out_data=0,
//    out_ch=0, out_sof=0, out_eof=0, busy=0, overrun=0, drop_cnt=0; shadow regs to 0.
//    A frame in progress is abandoned; no partial words after reset deasserts.
//  - FSM states: IDLE, DRAIN.
//    IDLE:  in_strobe=1 -> capture all NUM_CH words to shadow, ch_ptr=0, go DRAIN.
//    DRAIN: out_valid=1, out_data=shadow[ch_ptr], out_ch=ch_ptr.
//           transfer = out_valid & out_ready. On transfer with ch_ptr<NUM_CH-1: ch_ptr++.
//           On transfer with ch_ptr==NUM_CH-1: if in_strobe same cycle -> recapture,
//           ch_ptr=0, stay DRAIN (back-to-back frames, no bubble); else go IDLE.
//  - Latency: strobe at edge N -> out_valid=1 with ch 0 registered by edge N+1.
//    With out_ready held high a frame occupies exactly NUM_CH consecutive cycles.
//  - Handshake: while out_valid=1 and out_ready=0, all out_* held stable; out_valid never
//    drops without a transfer (except on reset). out_valid is not gated by out_ready.
//  - Drop rule: in_strobe in DRAIN without the final transfer in that same cycle -> data
//    ignored, shadow untouched, overrun<=1, drop_cnt<=drop_cnt+1 saturating at all-ones.
//  - clr_ovr: overrun<=0, drop_cnt<=0. If a drop occurs in the same cycle, drop wins:
//    overrun=1, drop_cnt=1.
//  - in_data sampled only on accepted strobes; changes at other times have no effect.
//  - busy = (state==DRAIN). All outputs are registered.
// TESTING
//  1 Reset, strobe once with ch j data = 0x100000+j, out_ready=1 -> 12 words, ch 0..11,
//    data matches, sof only on ch0, eof only on ch11, out_valid low after, busy 12 cycles.
//  2 Same frame, out_ready toggled 1,0,0,1,... -> every word held stable while stalled,
//    no loss/duplication, ordering 0..11 preserved.
//  3 Strobe every 12 cycles, out_ready=1 -> strobe coincides with ch11 transfer; frames
//    back-to-back, no bubble, overrun stays 0.
//  4 Strobe at ch 5 of draining frame -> frame continues with original data, overrun=1,
//    drop_cnt=1; 300 extra mid-frame strobes -> drop_cnt saturates at 255; clr_ovr -> 0/0.
//  5 Assert reset at ch 7 with out_ready=0 -> next cycle out_valid=0, all outputs 0;
//    following strobe starts a fresh frame at ch 0.
//  6 clr_ovr and drop strobe in same cycle -> overrun=1, drop_cnt=1.

Source files
------------

// File: rtl/cic3_row_readout_serializer.sv
// cic3_row_readout_serializer
// Snapshots one decimated sample set from the 1x12 CIC3 filter row into shadow
// registers and streams it out one channel per valid/ready transfer, tagged with
// the channel index and start/end-of-frame flags. Strobes that arrive while a
// frame is still draining are dropped, counted and flagged as overrun.
module cic3_row_readout_serializer #(
  parameter int NUM_CH = 12,
  parameter int DATA_W = 25,
  parameter int CH_W   = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_strobe,
  input  logic                     clr_ovr,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     overrun,
  output logic [DROP_W-1:0]        drop_cnt
);

  // Two-state frame sequencer: waiting for a strobe, or draining a snapshot.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [0:0]        state;
  logic [CH_W-1:0]   ch_ptr;
  logic [CH_W-1:0]   next_ptr;
  logic [DATA_W-1:0] shadow [NUM_CH];

  logic transfer;
  logic last_word;
  logic frame_done;
  logic advance;
  logic capture;
  logic drop;

  // The channel pointer is the register that tags each outgoing word.
  assign out_ch = ch_ptr;

  // Handshake and strobe qualification. A strobe is only accepted when the row
  // is idle or when the final word of the current frame leaves in the same
  // cycle, which lets frames run back-to-back without a bubble.
  always_comb begin
    transfer   = out_valid & out_ready;
    last_word  = (ch_ptr == LAST_CH);
    frame_done = transfer & last_word;
    advance    = transfer & ~last_word;
    capture    = in_strobe & ((state == IDLE) | frame_done);
    drop       = in_strobe & (state == DRAIN) & ~frame_done;
    next_ptr   = ch_ptr + CH_W'(1);
  end

  // Frame sequencer: enter DRAIN on an accepted strobe, fall back to IDLE
  // only once the last word has been taken and no new frame follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (capture) begin
      state <= DRAIN;
    end else if (frame_done) begin
      state <= IDLE;
    end
  end

  // Channel pointer: restarts at 0 on each captured frame, steps on transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_ptr <= '0;
    end else if (capture) begin
      ch_ptr <= '0;
    end else if (advance) begin
      ch_ptr <= next_ptr;
    end
  end

  // Shadow snapshot of the whole row; untouched by dropped strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_CH; j++) begin
        shadow[j] <= '0;
      end
    end else if (capture) begin
      for (int j = 0; j < NUM_CH; j++) begin
        shadow[j] <= in_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Output word register. Channel 0 comes straight from in_data on capture so
  // it is presented one edge after the strobe; later channels come from shadow.
  // Nothing changes while stalled, which keeps the word stable for the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (capture) begin
      out_data <= in_data[DATA_W-1:0];
    end else if (advance) begin
      out_data <= shadow[next_ptr];
    end
  end

  // Valid/busy and framing flags. Flags are only ever high alongside valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      busy      <= 1'b1;
      out_sof   <= 1'b1;
      out_eof   <= (LAST_CH == '0);
    end else if (advance) begin
      out_sof   <= 1'b0;
      out_eof   <= (next_ptr == LAST_CH);
    end else if (frame_done) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

  // Overrun bookkeeping. A drop in the same cycle as a clear wins, leaving the
  // flag set and the counter at exactly one. The counter saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clr_ovr) begin
        drop_cnt <= DROP_W'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end else if (clr_ovr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cic3_row_readout_serializer.sv
// tb_cic3_row_readout_serializer
// Drives the row serializer cycle by cycle and compares it against a
// queue-based model of the frame stream and the overrun bookkeeping.
module tb_cic3_row_readout_serializer;

  localparam int NUM_CH = 12;
  localparam int DATA_W = 25;
  localparam int CH_W   = 4;
  localparam int DROP_W = 8;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_strobe;
  logic                     clr_ovr;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_sof;
  logic                     out_eof;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     overrun;
  logic [DROP_W-1:0]        drop_cnt;

  int tests_run;
  int tests_failed;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } word_t;

  word_t       exp_q[$];
  logic        m_ovr;
  int          m_cnt;

  cic3_row_readout_serializer #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .CH_W  (CH_W),
    .DROP_W(DROP_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_strobe(in_strobe),
    .clr_ovr  (clr_ovr),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun),
    .drop_cnt (drop_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts it and reports any difference
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fill in_data with a fixed pattern (ch j = 0x100000 + j)
  task automatic set_pattern_data();
    for (int j = 0; j < NUM_CH; j++) begin
      in_data[j*DATA_W +: DATA_W] = DATA_W'(32'h100000 + j);
    end
  endtask

  // Fill in_data with random 25-bit words
  task automatic set_random_data();
    for (int j = 0; j < NUM_CH; j++) begin
      in_data[j*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  // Model of one clock edge: the current frame is a queue of words still owed
  task automatic model_edge(input logic strobe, input logic ready, input logic clr, input logic rst);
    bit was_valid;
    bit hs;
    bit last_taken;
    if (rst) begin
      exp_q.delete();
      m_ovr = 1'b0;
      m_cnt = 0;
      return;
    end
    was_valid  = (exp_q.size() != 0);
    hs         = was_valid && ready;
    last_taken = hs && (exp_q.size() == 1);
    if (hs) void'(exp_q.pop_front());
    if (strobe && (!was_valid || last_taken)) begin
      for (int j = 0; j < NUM_CH; j++) begin
        word_t w;
        w.ch   = j;
        w.data = 32'(in_data[j*DATA_W +: DATA_W]);
        exp_q.push_back(w);
      end
      if (clr) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
    end else if (strobe) begin
      m_ovr = 1'b1;
      if (clr) m_cnt = 1;
      else if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (clr) begin
      m_ovr = 1'b0;
      m_cnt = 0;
    end
  endtask

  // Compare every output against the model
  task automatic checkOutput(input bit after_reset);
    bit v;
    v = (exp_q.size() != 0);
    check_eq("out_valid", 32'(out_valid), 32'(v));
    check_eq("busy", 32'(busy), 32'(v));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    if (v) begin
      check_eq("out_data", 32'(out_data), exp_q[0].data);
      check_eq("out_ch", 32'(out_ch), 32'(exp_q[0].ch));
      check_eq("out_sof", 32'(out_sof), 32'(exp_q[0].ch == 0));
      check_eq("out_eof", 32'(out_eof), 32'(exp_q[0].ch == NUM_CH - 1));
    end else begin
      check_eq("out_sof_idle", 32'(out_sof), 32'd0);
      check_eq("out_eof_idle", 32'(out_eof), 32'd0);
    end
    if (after_reset) begin
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_ch", 32'(out_ch), 32'd0);
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check after it
  task automatic applyStimulus(input logic strobe, input logic ready, input logic clr, input logic rst);
    in_strobe = strobe;
    out_ready = ready;
    clr_ovr   = clr;
    reset     = rst;
    @(posedge clk);
    model_edge(strobe, ready, clr, rst);
    #1;
    checkOutput(rst);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_ovr        = 1'b0;
    m_cnt        = 0;
    in_data      = '0;
    in_strobe    = 1'b0;
    clr_ovr      = 1'b0;
    out_ready    = 1'b0;
    reset        = 1'b1;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Single frame with fixed pattern, consumer always ready
    set_pattern_data();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t1_first_data", 32'(out_data), 32'h100000);
    set_random_data();
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t1_valid_after", 32'(out_valid), 32'd0);

    // Same frame with a stalling consumer (ready 1,0,0,...)
    set_pattern_data();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    set_random_data();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, (i % 3) == 0, 1'b0, 1'b0);

    // Back-to-back frames: strobe coincides with the last transfer
    for (int i = 0; i < 48; i++) begin
      if (i % 12 == 0) set_random_data();
      applyStimulus((i % 12) == 0, 1'b1, 1'b0, 1'b0);
    end
    check_eq("t3_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Mid-frame drop at ch 5, then saturating drop counter, then clear
    set_random_data();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    set_random_data();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    check_eq("t4_drop1", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4_drop_sat", 32'(drop_cnt), 32'd255);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_clr_ovr", 32'(overrun), 32'd0);
    check_eq("t4_clr_cnt", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame at ch 7 with consumer stalled, then a fresh frame
    set_random_data();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t5_at_ch7", 32'(out_ch), 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t5_valid_rst", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    set_random_data();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t5_fresh_ch", 32'(out_ch), 32'd0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Clear and drop in the same cycle: drop wins
    set_random_data();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t6_drop2", 32'(drop_cnt), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("t6_ovr", 32'(overrun), 32'd1);
    check_eq("t6_cnt", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_random_data();
      applyStimulus($urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0,
                    $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
